// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port between in-order
//            pipeline writeback and a queued long-latency (mul/div) unit.
//            Includes starvation-forced stall and pending-write hazard query.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [4:0]        pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [4:0]        ll_rd,
    input  logic [DATA_W-1:0] ll_data,
    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_data,
    output logic              pipe_stall,
    input  logic [4:0]        q_rs1,
    input  logic [4:0]        q_rs2,
    output logic              q_rs1_pending,
    output logic              q_rs2_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // FIFO storage and bookkeeping
    logic [4:0]        rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Starvation FSM
    logic [0:0]        state_q, state_d;
    logic [STV_W-1:0]  stv_q, stv_d;

    // Registered write port
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic fifo_empty;
    logic pw;
    logic pop;
    logic enq;

    assign fifo_empty = (count_q == '0);
    // Slot availability looks only at the registered count, so a same-cycle
    // pop never frees room for a same-cycle enqueue.
    assign ll_ready   = (count_q != CNT_W'(DEPTH));
    assign pipe_stall = (state_q == ST_STALL);
    assign pw         = pipe_we && (pipe_rd != 5'd0) && !pipe_stall;
    assign pop        = !pw && !fifo_empty;
    // x0 results complete the handshake but are dropped here.
    assign enq        = ll_valid && ll_ready && (ll_rd != 5'd0);

    assign rf_we   = rf_we_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;

    // Hazard query: any valid queued entry (including the one being popped) matches
    always_comb begin
        q_rs1_pending = 1'b0;
        q_rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (rd_mem_q[i] == q_rs1) && (q_rs1 != 5'd0)) begin
                q_rs1_pending = 1'b1;
            end
            if (valid_q[i] && (rd_mem_q[i] == q_rs2) && (q_rs2 != 5'd0)) begin
                q_rs2_pending = 1'b1;
            end
        end
    end

    // FIFO pointer, occupancy and valid-bit next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (enq && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Write-port grant: pipeline first, otherwise drain the FIFO head
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (pw) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = pipe_rd;
            rf_data_d = pipe_data;
        end else if (pop) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = rd_mem_q[rd_ptr_q];
            rf_data_d = data_mem_q[rd_ptr_q];
        end
    end

    // Starvation FSM: count non-draining cycles, then force a one-cycle stall
    always_comb begin
        state_d = state_q;
        stv_d   = stv_q;
        case (state_q)
            ST_RUN: begin
                if (pop || fifo_empty) begin
                    stv_d = '0;
                end else if (stv_q == STV_W'(STARVE_LIMIT - 1)) begin
                    state_d = ST_STALL;
                    stv_d   = '0;
                end else begin
                    stv_d = stv_q + STV_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                stv_d   = '0;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_RUN;
            stv_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            stv_q     <= stv_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by valid_q
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem_q[wr_ptr_q]   <= ll_rd;
            data_mem_q[wr_ptr_q] <= ll_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between the in-order pipeline writeback (MEM/WB outputs) and a long-latency unit (mul/div) that returns results out of band.
- Long-latency results are queued in a small FIFO and drained in cycles where the pipeline does not write.
- A starvation counter forces a one-cycle pipeline stall so queued results always retire.
- The block also reports which registers still have queued writes, for hazard detection.

Parameters:
- DEPTH, 2: FIFO entries for long-latency results (power of 2, >=2).
- STARVE_LIMIT, 4: consecutive non-draining cycles with FIFO non-empty before a stall is forced (>=1).
- DATA_W, 32: write data width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-low reset (rst==0 at posedge resets).
- pipe_we  input  1  pipeline WB write request.
- pipe_rd  input  5  pipeline WB destination register.
- pipe_data  input  DATA_W  pipeline WB data.
- ll_valid  input  1  long-latency result valid.
- ll_ready  output  1  arbiter can accept a long-latency result.
- ll_rd  input  5  long-latency destination register.
- ll_data  input  DATA_W  long-latency result data.
- rf_we  output  1  register-file write enable (registered).
- rf_rd  output  5  register-file write address (registered).
- rf_data  output  DATA_W  register-file write data (registered).
- pipe_stall  output  1  holds MEM/WB and earlier stages this cycle (registered).
- q_rs1  input  5  hazard query address 1.
- q_rs2  input  5  hazard query address 2.
- q_rs1_pending  output  1  a queued entry targets q_rs1 (combinational).
- q_rs2_pending  output  1  a queued entry targets q_rs2 (combinational).

Behaviour:
- Reset (rst==0 at posedge):
  - FIFO emptied; read/write pointers and count set to 0.
  - Starvation counter set to 0.
  - rf_we, rf_rd, rf_data and pipe_stall set to 0.
  - Reset mid-operation discards all queued results. No rf write occurs in the following cycle.
- Enqueue:
  - ll_ready = (count != DEPTH). It is derived from the registered count only; a pop in the same cycle does not free a slot.
  - A handshake is ll_valid && ll_ready.
  - ll_rd==0 handshakes complete but are not enqueued.
- Per-cycle grant (combinational, then registered into rf_*). Let pw = pipe_we && pipe_rd!=0 && !pipe_stall.
  - pw=1: next rf_we=1, rf_rd=pipe_rd, rf_data=pipe_data. The FIFO is not popped.
  - Else, FIFO non-empty: next rf_* = head entry, rf_we=1, head popped.
  - Else: next rf_we=0; rf_rd and rf_data hold their previous values.
- Latency:
  - Pipeline write appears on rf_* 1 cycle after presentation.
  - A long-latency result appears at the earliest 2 cycles after its handshake (enqueue, then pop).
- Simultaneous enqueue and pop: both happen and count is unchanged. Entry order is strictly FIFO.
- Starvation FSM, states RUN and STALL (pipe_stall = state==STALL):
  - RUN: the counter increments when the FIFO is non-empty and no pop occurs. It clears on any pop or when the FIFO is empty.
  - RUN -> STALL when the counter reaches STARVE_LIMIT.
  - STALL: lasts exactly one cycle. pipe_we is ignored (pw=0), so the head is popped. Then the FSM returns to RUN with the counter at 0.
  - Enqueue is still allowed during STALL.
- Hazard query:
  - q_rsN_pending=1 iff q_rsN!=0 and some valid FIFO entry has rd==q_rsN.
  - An entry popped this cycle still counts as pending this cycle.
  - A same-cycle incoming ll beat is not included.
- Register x0 is never written: rd==0 requests from either source produce rf_we=0.

Test Plan:
- Reset, then idle: rst=0 for 2 cycles, release -> rf_we=0, pipe_stall=0, ll_ready=1. Present ll_valid, rd=5, data=0x11 with pipe_we=0 -> next cycle FIFO holds 1 entry and q_rs1=5 gives pending=1. The cycle after: rf_we=1, rf_rd=5, rf_data=0x11.
- Pipeline priority: FIFO holds rd=7; pipe_we=1, rd=3, data=0xAA for 2 cycles -> rf writes x3 twice. The x7 write follows in the first cycle pipe_we=0, 1 cycle later.
- Full FIFO: enqueue rd=1 and rd=2 while pipe_we=1 continuously -> ll_ready=0 after 2 handshakes. A third ll_valid (rd=4) stalls with no enqueue. Order retired is x1, x2, x4.
- Starvation: FIFO holds rd=9, pipe_we=1 every cycle -> after STARVE_LIMIT=4 non-draining cycles pipe_stall=1 for exactly 1 cycle. rf writes x9 the next cycle; that cycle's pipe write is not performed.
- x0 handling: ll rd=0 handshake -> count unchanged. pipe_we=1 with rd=0 -> rf_we=0, and a queued entry drains in that cycle instead.
- Reset mid-op: FIFO holds 2 entries, assert rst=0 for 1 cycle -> pending flags 0, ll_ready=1, no rf_we afterwards.
